windowed_regfile: RTL and testbench
===================================

Name: windowed_regfile

Overview:
- SPARC-style windowed integer register file with four register windows.
- Sits directly downstream of the 2-to-4 window decoder: the 2-bit current-window pointer (CWP) is decoded one-hot to select the active 16-register bank for reads and writes.
- Provides two combinational read ports and one synchronous write port.
- Handles SAVE/RESTORE window rotation, with overflow/underflow traps gated by the window invalid mask (WIM).

Parameters:
DATA_W, 32, width of every register and data port
(NWIN is fixed at 4 and is not a parameter; the CWP is 2 bits.)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rs1  input  5  logical read address, port 1
rs2  input  5  logical read address, port 2
rd1  output  DATA_W  read data, port 1 (combinational)
rd2  output  DATA_W  read data, port 2 (combinational)
wr_en  input  1  write enable
wr_addr  input  5  logical write address
wr_data  input  DATA_W  write data
save  input  1  SAVE request (single-cycle pulse)
restore  input  1  RESTORE request (single-cycle pulse)
wim_we  input  1  load WIM from wim_d
wim_d  input  4  new WIM value
cwp  output  2  current window pointer
wim  output  4  window invalid mask
ovf_trap  output  1  window-overflow trap, registered one-cycle pulse
unf_trap  output  1  window-underflow trap, registered one-cycle pulse

Behaviour:

Physical storage:
- 72 registers: 8 globals plus 4 banks of 16.
- Bank b, slot s maps to physical index 8 + 16*b + s.
- Slots 0-7 hold the ins of bank b; slots 8-15 hold its locals.

Logical-to-physical map, using the CWP value current in that cycle:
- r0-r7 map to global r.
- r8-r15 (outs) map to bank (cwp-1) mod 4, slot r-8.
- r16-r23 (locals) map to bank cwp, slot r-8.
- r24-r31 (ins) map to bank cwp, slot r-24.
- Bank selection uses the one-hot decode of the 2-bit bank number.

Register r0:
- Always reads 0.
- Writes to r0 are discarded.

Reads:
- Purely combinational from stored contents. No write-to-read bypass.
- A read of the address being written in the same cycle returns the old value; the new value is visible the cycle after the clock edge.

Writes:
- Occur on the rising edge when wr_en=1.
- Use the pre-edge CWP for address mapping, even if save or restore is asserted in the same cycle.

SAVE (save=1, restore=0):
- Target window is t = (cwp-1) mod 4.
- If wim[t]=1: CWP is unchanged and ovf_trap=1 for the next cycle.
- Otherwise: cwp <= t.

RESTORE (restore=1, save=0):
- Target window is t = (cwp+1) mod 4.
- If wim[t]=1: CWP is unchanged and unf_trap=1 for the next cycle.
- Otherwise: cwp <= t.

Wrap-around: the CWP wraps modulo 4 in both directions (0 -> 3 on save, 3 -> 0 on restore).

Simultaneous events:
- save and restore together: ignored. CWP unchanged, no trap.
- wim_we in the same cycle as save/restore: the trap check uses the old WIM, and WIM updates on the same edge.

Trap outputs: ovf_trap and unf_trap are each high for exactly one cycle per offending request and are low otherwise.

Reset (asynchronous, rst_n=0):
- All 72 registers are cleared to 0.
- cwp=0, wim=4'b0000, ovf_trap=0, unf_trap=0.
- Therefore rd1 and rd2 read 0 during and after reset.
- Reset asserted mid-operation overrides any write, save, or restore in flight; state is cleared immediately, with no waiting for a clock edge.

Test Plan:
1. Reset: assert rst_n=0 mid-clock -> immediately cwp=0, wim=0, traps=0; rd1 and rd2 read 0 for every rs1/rs2 value.
2. Local write and r0 guard:
   - At cwp=0, write r17=0xDEADBEEF -> rd1=0xDEADBEEF on the next cycle, and the same-cycle read returns 0.
   - Write r0=0xFFFFFFFF -> r0 still reads 0.
3. Window overlap:
   - At cwp=0, write r9=0x00001234, then save -> cwp=3.
   - Read r25 -> 0x00001234.
   - r17 reads 0, since the bank 3 local is distinct from the bank 0 local.
4. Global visibility: write r5=0xA5A5A5A5 at cwp=0, save twice -> cwp=2 and r5 still reads 0xA5A5A5A5.
5. Overflow trap:
   - Load wim=4'b1000 at cwp=0, then save -> ovf_trap high for exactly 1 cycle and cwp stays 0.
   - Load wim=0 and save again -> cwp=3, no trap.
6. Underflow, wrap, and conflict:
   - At cwp=3 with wim=4'b0001, restore -> unf_trap pulse and cwp=3.
   - Clear wim, then restore -> cwp=0.
   - save and restore together -> no change, no trap.

Source files
------------

// File: rtl/windowed_regfile_if.sv
// Port bundle for the windowed register file: read/write ports, window
// control requests and the observable window state.
interface windowed_regfile_if #(parameter int DATA_W = 32);
  logic [4:0]        rs1, rs2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              save, restore;
  logic              wim_we;
  logic [3:0]        wim_d;
  logic [1:0]        cwp;
  logic [3:0]        wim;
  logic              ovf_trap, unf_trap;

  modport master (
    output rs1, rs2, wr_en, wr_addr, wr_data, save, restore, wim_we, wim_d,
    input  rd1, rd2, cwp, wim, ovf_trap, unf_trap
  );

  modport slave (
    input  rs1, rs2, wr_en, wr_addr, wr_data, save, restore, wim_we, wim_d,
    output rd1, rd2, cwp, wim, ovf_trap, unf_trap
  );
endinterface

// File: rtl/windowed_regfile.sv
// SPARC-style register file: 8 globals plus 4 windowed banks of 16, two
// combinational read ports, one write port, SAVE/RESTORE with WIM traps.
module wrf_bank #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        wslot,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        rslot1,
  input  logic [3:0]        rslot2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  // slots 0-7 are this bank's ins, 8-15 its locals
  logic [15:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (we) mem[wslot] <= wdata;
  end

  assign rdata1 = mem[rslot1];
  assign rdata2 = mem[rslot2];
endmodule

module windowed_regfile #(parameter int DATA_W = 32) (
  input logic               clk,
  input logic               rst_n,
  windowed_regfile_if.slave bus
);
  typedef struct packed {
    logic       glb;
    logic [1:0] bank;
    logic [3:0] slot;
  } loc_t;

  // outs live in the previous window's ins, so r8-r15 shift the bank by -1
  function automatic loc_t map_addr(input logic [4:0] a, input logic [1:0] w);
    loc_t l;
    l.glb  = (a[4:3] == 2'b00);
    l.bank = w;
    l.slot = {1'b0, a[2:0]};
    case (a[4:3])
      2'b01:   l.bank = w - 2'd1;
      2'b10:   l.slot = {1'b1, a[2:0]};
      default: ;
    endcase
    return l;
  endfunction

  logic [1:0] cwp_q;
  logic [3:0] wim_q;
  logic       ovf_q, unf_q;

  loc_t l1, l2, lw;
  assign l1 = map_addr(bus.rs1, cwp_q);
  assign l2 = map_addr(bus.rs2, cwp_q);
  assign lw = map_addr(bus.wr_addr, cwp_q);

  logic [3:0] wr_oh, rd1_oh, rd2_oh;
  assign wr_oh  = (bus.wr_en && !lw.glb) ? (4'b0001 << lw.bank) : 4'b0000;
  assign rd1_oh = 4'b0001 << l1.bank;
  assign rd2_oh = 4'b0001 << l2.bank;

  // globals; entry 0 is never written so r0 stays zero
  logic [7:0][DATA_W-1:0] glb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glb_q <= '0;
    else if (bus.wr_en && lw.glb && bus.wr_addr[2:0] != 3'd0)
      glb_q[bus.wr_addr[2:0]] <= bus.wr_data;
  end

  logic [3:0][DATA_W-1:0] b_rd1, b_rd2;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    wrf_bank #(.DATA_W(DATA_W)) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wr_oh[b]),
      .wslot  (lw.slot),
      .wdata  (bus.wr_data),
      .rslot1 (l1.slot),
      .rslot2 (l2.slot),
      .rdata1 (b_rd1[b]),
      .rdata2 (b_rd2[b])
    );
  end

  logic [DATA_W-1:0] rd1_v, rd2_v;

  always_comb begin
    rd1_v = '0;
    rd2_v = '0;
    for (int b = 0; b < 4; b++) begin
      if (rd1_oh[b]) rd1_v = rd1_v | b_rd1[b];
      if (rd2_oh[b]) rd2_v = rd2_v | b_rd2[b];
    end
    if (l1.glb) rd1_v = glb_q[bus.rs1[2:0]];
    if (l2.glb) rd2_v = glb_q[bus.rs2[2:0]];
  end

  assign bus.rd1 = rd1_v;
  assign bus.rd2 = rd2_v;

  // window control; trap checks see the pre-edge WIM
  logic       save_req, restore_req;
  logic [1:0] save_t, restore_t;
  assign save_req    = bus.save & ~bus.restore;
  assign restore_req = bus.restore & ~bus.save;
  assign save_t      = cwp_q - 2'd1;
  assign restore_t   = cwp_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp_q <= 2'd0;
      wim_q <= 4'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      if (bus.wim_we) wim_q <= bus.wim_d;
      if (save_req) begin
        if (wim_q[save_t]) ovf_q <= 1'b1;
        else               cwp_q <= save_t;
      end
      if (restore_req) begin
        if (wim_q[restore_t]) unf_q <= 1'b1;
        else                  cwp_q <= restore_t;
      end
    end
  end

  assign bus.cwp      = cwp_q;
  assign bus.wim      = wim_q;
  assign bus.ovf_trap = ovf_q;
  assign bus.unf_trap = unf_q;
endmodule

// File: tb/tb_windowed_regfile.sv
// Directed bench for windowed_regfile: reset, r0 guard, window overlap,
// globals, overflow/underflow traps, wrap, conflicts and async reset.
module tb_windowed_regfile;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  windowed_regfile_if #(.DATA_W(32)) bus ();

  windowed_regfile #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
    bus.save = 1'b0; bus.restore = 1'b0;
    bus.wim_we = 1'b0; bus.wim_d = 4'd0;
    #2;
    chk("rst_cwp", 32'(bus.cwp), 32'd0);
    chk("rst_wim", 32'(bus.wim), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_trap), 32'd0);
    chk("rst_unf", 32'(bus.unf_trap), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(31 - i);
      #0.1;
      chk("rst_rd1", bus.rd1, 32'd0);
      chk("rst_rd2", bus.rd2, 32'd0);
    end
    step();
    rst_n = 1'b1;
    step();

    // local write, same-cycle read returns old value
    bus.wr_en = 1'b1; bus.wr_addr = 5'd17; bus.wr_data = 32'hDEADBEEF; bus.rs1 = 5'd17;
    #1;
    chk("r17_same_cycle", bus.rd1, 32'd0);
    step();
    bus.wr_en = 1'b0;
    chk("r17_next_cycle", bus.rd1, 32'hDEADBEEF);

    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF; bus.rs2 = 5'd0;
    step();
    bus.wr_en = 1'b0;
    chk("r0_guard", bus.rd2, 32'd0);

    // outs of window 0 become ins of window 3
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h00001234;
    step();
    bus.wr_en = 1'b0; bus.save = 1'b1;
    step();
    bus.save = 1'b0;
    chk("save_cwp3", 32'(bus.cwp), 32'd3);
    bus.rs1 = 5'd25; bus.rs2 = 5'd17;
    #1;
    chk("overlap_r25", bus.rd1, 32'h00001234);
    chk("bank3_local_r17", bus.rd2, 32'd0);

    bus.restore = 1'b1;
    step();
    bus.restore = 1'b0;
    chk("restore_cwp0", 32'(bus.cwp), 32'd0);
    bus.rs1 = 5'd17;
    #1;
    chk("r17_back_cwp0", bus.rd1, 32'hDEADBEEF);

    // globals are window-independent
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hA5A5A5A5;
    step();
    bus.wr_en = 1'b0; bus.save = 1'b1;
    step();
    step();
    bus.save = 1'b0;
    chk("save2_cwp2", 32'(bus.cwp), 32'd2);
    bus.rs1 = 5'd5;
    #1;
    chk("global_r5", bus.rd1, 32'hA5A5A5A5);

    bus.restore = 1'b1;
    step();
    step();
    bus.restore = 1'b0;
    chk("restore2_cwp0", 32'(bus.cwp), 32'd0);

    // overflow trap
    bus.wim_we = 1'b1; bus.wim_d = 4'b1000;
    step();
    bus.wim_we = 1'b0;
    chk("wim_load", 32'(bus.wim), 32'h8);
    bus.save = 1'b1;
    step();
    bus.save = 1'b0;
    chk("ovf_pulse", 32'(bus.ovf_trap), 32'd1);
    chk("ovf_cwp_hold", 32'(bus.cwp), 32'd0);
    chk("ovf_no_unf", 32'(bus.unf_trap), 32'd0);
    step();
    chk("ovf_one_cycle", 32'(bus.ovf_trap), 32'd0);
    bus.wim_we = 1'b1; bus.wim_d = 4'b0000;
    step();
    bus.wim_we = 1'b0; bus.save = 1'b1;
    step();
    bus.save = 1'b0;
    chk("save_wrap_cwp3", 32'(bus.cwp), 32'd3);
    chk("save_wrap_no_ovf", 32'(bus.ovf_trap), 32'd0);

    // underflow trap, wrap 3 -> 0
    bus.wim_we = 1'b1; bus.wim_d = 4'b0001;
    step();
    bus.wim_we = 1'b0; bus.restore = 1'b1;
    step();
    bus.restore = 1'b0;
    chk("unf_pulse", 32'(bus.unf_trap), 32'd1);
    chk("unf_cwp_hold", 32'(bus.cwp), 32'd3);
    step();
    chk("unf_one_cycle", 32'(bus.unf_trap), 32'd0);
    bus.wim_we = 1'b1; bus.wim_d = 4'b0000;
    step();
    bus.wim_we = 1'b0; bus.restore = 1'b1;
    step();
    bus.restore = 1'b0;
    chk("restore_wrap_cwp0", 32'(bus.cwp), 32'd0);
    chk("restore_wrap_no_unf", 32'(bus.unf_trap), 32'd0);

    bus.save = 1'b1; bus.restore = 1'b1;
    step();
    bus.save = 1'b0; bus.restore = 1'b0;
    chk("conflict_cwp", 32'(bus.cwp), 32'd0);
    chk("conflict_ovf", 32'(bus.ovf_trap), 32'd0);
    chk("conflict_unf", 32'(bus.unf_trap), 32'd0);

    // WIM load alongside save: check uses old WIM (0), new WIM lands
    bus.save = 1'b1; bus.wim_we = 1'b1; bus.wim_d = 4'b1000;
    step();
    bus.save = 1'b0; bus.wim_we = 1'b0;
    chk("wimwe_save_cwp", 32'(bus.cwp), 32'd3);
    chk("wimwe_save_no_ovf", 32'(bus.ovf_trap), 32'd0);
    chk("wimwe_save_wim", 32'(bus.wim), 32'h8);

    // write in a SAVE cycle maps through the pre-edge CWP (bank 3 local)
    bus.wr_en = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 32'h00000055;
    bus.save = 1'b1; bus.wim_we = 1'b1; bus.wim_d = 4'b0100;
    step();
    bus.wr_en = 1'b0; bus.save = 1'b0; bus.wim_we = 1'b0;
    chk("wr_save_cwp2", 32'(bus.cwp), 32'd2);
    bus.rs1 = 5'd16;
    #1;
    chk("wr_save_bank2_r16", bus.rd1, 32'd0);
    bus.restore = 1'b1;
    step();
    bus.restore = 1'b0;
    chk("wr_save_back_cwp3", 32'(bus.cwp), 32'd3);
    chk("wr_save_bank3_r16", bus.rd1, 32'h00000055);

    // asynchronous reset mid-cycle
    bus.rs1 = 5'd16; bus.rs2 = 5'd5;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cwp", 32'(bus.cwp), 32'd0);
    chk("arst_wim", 32'(bus.wim), 32'd0);
    chk("arst_rd1", bus.rd1, 32'd0);
    chk("arst_rd2", bus.rd2, 32'd0);
    bus.rs1 = 5'd17;
    #1;
    chk("arst_r17", bus.rd1, 32'd0);
    step();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
